word_sprite_ctrl: RTL
=====================

Name: word_sprite_ctrl

Overview:
- Sequences on-screen drawing of a 4-bit-indexed word sprite (title/banner text) for the VGA pixel path.
- Turns DrawX/DrawY into a sprite ROM address and feeds the returned index into the sprite's colour palette.
- Applies transparency and outputs registered RGB plus a sprite_on flag to the colour mapper.
- Contains a frame-synchronous show/blink/hide state machine, so the word appears, blinks, then stays up or disappears without tearing mid-frame.

Parameters:
- POS_X, 10'd200: left edge of the sprite box, in screen pixels.
- POS_Y, 10'd120: top edge of the sprite box, in screen pixels.
- WIDTH, 240: sprite width in pixels.
- HEIGHT, 40: sprite height in pixels.
- ADDR_W, 14: ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- BLINK_FRAMES, 15: frames per blink half-period.
- BLINK_COUNT, 6: visibility toggles performed before settling in SHOWN.

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse at the start of vertical blanking
- show  in  1  one-cycle request to display the word (enters blink sequence)
- hide  in  1  one-cycle request to remove the word
- rom_addr  out  ADDR_W  address to the sprite ROM (1-cycle read latency)
- rom_data  in  4  palette index returned by the ROM
- pal_index  out  4  index driven to the palette (combinational lookup)
- pal_red, pal_green, pal_blue  in  4 each  palette output
- sprite_on  out  1  registered: this pixel is drawn by the sprite
- red, green, blue  out  4 each  registered sprite colour
- state  out  2  00 HIDDEN, 01 BLINK, 10 SHOWN (debug/status)

Behaviour:
- Reset (async assert, sync release): state=HIDDEN; all counters, pending flags, pipeline valids, sprite_on, red/green/blue, rom_addr and pal_index = 0.
- Stage 0 (combinational to register):
  - in_box = (DrawX >= POS_X) && (DrawX < POS_X+WIDTH) && (DrawY >= POS_Y) && (DrawY < POS_Y+HEIGHT). Compare in 11 bits; no wrap.
  - rom_addr = (DrawY-POS_Y)*WIDTH + (DrawX-POS_X), truncated to ADDR_W. Drive 0 when not in_box.
  - Register in_box into v1.
- Stage 1:
  - pal_index = rom_data when v1, else 0.
  - Register into the output stage: sprite_on = v1 && visible && (rom_data != 0); red/green/blue = pal_* when sprite_on, else 0.
- Latency: exactly 2 Clk from DrawX/DrawY to sprite_on/RGB.
- Transparency: index 0 is transparent. Never assert sprite_on for index 0.
- Request capture: show or hide sets a pending flag on any cycle. Pending flags are applied only on a cycle with frame_tick=1, then cleared. hide has priority over show when both are pending or asserted together.
- States, evaluated on frame_tick:
  - HIDDEN: visible=0. Pending show -> BLINK with blink_frames=0, toggles=0, visible=1.
  - BLINK: blink_frames increments each frame_tick. When it reaches BLINK_FRAMES-1: reset it, invert visible, increment toggles. When toggles reaches BLINK_COUNT: go to SHOWN, visible=1. Pending hide -> HIDDEN.
  - SHOWN: visible=1. Pending hide -> HIDDEN. Pending show restarts BLINK.
- visible only changes on a frame_tick cycle, so a frame never mixes visibility.
- A show pulse on the same cycle as frame_tick is applied on that frame_tick.
- Reset mid-frame: outputs go to 0 immediately; the pipeline refills with valid data 2 cycles after release.

Test Plan:
- Reset, then show + frame_tick; sweep DrawX 199..202 at DrawY=120 with rom_data=5 and pal=(D,C,7) -> sprite_on=0 at X=199, 1 for X=200..202, RGB=D,C,7, 2 cycles later; rom_addr=0,1,2.
- Shown, DrawX=439/440 at DrawY=159/160 -> in_box only at (439,159), rom_addr=9599; nothing drawn outside the box.
- rom_data=0 inside the box while visible -> sprite_on=0, RGB=0.
- show then 90 frame_ticks -> visible toggles every 15 ticks (6 toggles), state=SHOWN after tick 90, visible=1.
- show and hide on the same cycle while SHOWN, followed by frame_tick -> HIDDEN, sprite_on=0 on the next frame; hide pulsed mid-frame -> no change until the next frame_tick.
- Reset_n asserted mid-line while drawing -> sprite_on/RGB=0 asynchronously; after release, state=HIDDEN.

Source files
------------

// File: rtl/word_sprite_ctrl.sv
// word_sprite_ctrl: draws a 4-bit-indexed word sprite (title/banner text) into the VGA
// pixel path.
//
// Pipeline:
//   stage 0 - box test on DrawX/DrawY, ROM address generation, in_box registered as v1
//   stage 1 - ROM index drives the palette, transparency and visibility applied, result
//             registered into sprite_on / red / green / blue
//   Total latency from DrawX/DrawY to sprite_on/RGB is 2 Clk.
//
// A frame-synchronous HIDDEN/BLINK/SHOWN state machine gates visibility. show/hide
// requests are latched and only applied on frame_tick, so a frame never mixes states.
//
// Ports:
//   Clk, Reset_n          pixel clock, asynchronous active-low reset
//   DrawX, DrawY          current pixel column/row
//   frame_tick            one-cycle pulse at start of vertical blanking
//   show, hide            one-cycle display/remove requests (hide wins)
//   rom_addr, rom_data    sprite ROM address out (comb), palette index back (1-cycle latency)
//   pal_index             index to the palette (comb); pal_red/green/blue come back
//   sprite_on, red/green/blue  registered sprite pixel flag and colour
//   state                 00 HIDDEN, 01 BLINK, 10 SHOWN
module word_sprite_ctrl #(
    parameter logic [9:0]  POS_X        = 10'd200,
    parameter logic [9:0]  POS_Y        = 10'd120,
    parameter int unsigned WIDTH        = 240,
    parameter int unsigned HEIGHT       = 40,
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned BLINK_FRAMES = 15,
    parameter int unsigned BLINK_COUNT  = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              frame_tick,
    input  logic              show,
    input  logic              hide,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic              sprite_on,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [1:0]        state
);

    localparam int unsigned FramesW = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned TogW    = $clog2(BLINK_COUNT + 1);

    typedef enum logic [1:0] {
        StHidden = 2'b00,
        StBlink  = 2'b01,
        StShown  = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Stage 0: box test and ROM address
    // ------------------------------------------------------------------
    logic [10:0]       x_ext, y_ext;
    logic [10:0]       x_lo, x_hi, y_lo, y_hi;
    logic              in_box;
    logic [9:0]        rel_x, rel_y;
    logic [ADDR_W-1:0] addr_lin;

    // Compare in 11 bits so POS + size cannot wrap past 1023.
    assign x_ext = {1'b0, DrawX};
    assign y_ext = {1'b0, DrawY};
    assign x_lo  = {1'b0, POS_X};
    assign y_lo  = {1'b0, POS_Y};
    assign x_hi  = {1'b0, POS_X} + 11'(WIDTH);
    assign y_hi  = {1'b0, POS_Y} + 11'(HEIGHT);

    assign in_box = (x_ext >= x_lo) && (x_ext < x_hi) &&
                    (y_ext >= y_lo) && (y_ext < y_hi);

    assign rel_x    = DrawX - POS_X;
    assign rel_y    = DrawY - POS_Y;
    // Computed directly at ADDR_W bits: truncation is modulo 2^ADDR_W either way.
    assign addr_lin = ADDR_W'(rel_y) * ADDR_W'(WIDTH) + ADDR_W'(rel_x);

    // The ROM latches this address on the next edge, so it stays combinational to keep
    // the total latency at 2. Held at 0 while reset is asserted.
    assign rom_addr = (in_box && Reset_n) ? addr_lin : '0;

    // ------------------------------------------------------------------
    // Frame-synchronous visibility state machine
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               visible_q, visible_d;
    logic [FramesW-1:0] frames_q, frames_d;
    logic [TogW-1:0]    toggles_q, toggles_d;
    logic               show_pend_q, show_pend_d;
    logic               hide_pend_q, hide_pend_d;
    logic               show_req, hide_req;

    // A request arriving on the frame_tick cycle itself is applied on that tick.
    assign show_req = show_pend_q | show;
    assign hide_req = hide_pend_q | hide;

    always_comb begin
        state_d     = state_q;
        visible_d   = visible_q;
        frames_d    = frames_q;
        toggles_d   = toggles_q;
        show_pend_d = show_req;
        hide_pend_d = hide_req;

        if (frame_tick) begin
            show_pend_d = 1'b0;
            hide_pend_d = 1'b0;
            if (hide_req) begin
                state_d   = StHidden;
                visible_d = 1'b0;
                frames_d  = '0;
                toggles_d = '0;
            end else if (show_req) begin
                // Entering or restarting the blink sequence.
                state_d   = StBlink;
                visible_d = 1'b1;
                frames_d  = '0;
                toggles_d = '0;
            end else begin
                unique case (state_q)
                    StBlink: begin
                        if (frames_q == FramesW'(BLINK_FRAMES - 1)) begin
                            frames_d  = '0;
                            visible_d = ~visible_q;
                            toggles_d = toggles_q + 1'b1;
                            if (toggles_d == TogW'(BLINK_COUNT)) begin
                                state_d   = StShown;
                                visible_d = 1'b1;
                            end
                        end else begin
                            frames_d = frames_q + 1'b1;
                        end
                    end
                    StShown: begin
                        visible_d = 1'b1;
                    end
                    default: begin
                        // StHidden, and recovery from the unused encoding.
                        state_d   = StHidden;
                        visible_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: palette lookup, transparency, visibility
    // ------------------------------------------------------------------
    logic       v1_q, v1_d;
    logic       sprite_on_q, sprite_on_d;
    logic [3:0] red_q, red_d;
    logic [3:0] green_q, green_d;
    logic [3:0] blue_q, blue_d;

    assign v1_d      = in_box;
    assign pal_index = v1_q ? rom_data : 4'd0;

    always_comb begin
        // Index 0 is the transparent colour.
        sprite_on_d = v1_q && visible_q && (rom_data != 4'd0);
        red_d       = 4'd0;
        green_d     = 4'd0;
        blue_d      = 4'd0;
        if (sprite_on_d) begin
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StHidden;
            visible_q   <= 1'b0;
            frames_q    <= '0;
            toggles_q   <= '0;
            show_pend_q <= 1'b0;
            hide_pend_q <= 1'b0;
            v1_q        <= 1'b0;
            sprite_on_q <= 1'b0;
            red_q       <= 4'd0;
            green_q     <= 4'd0;
            blue_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            visible_q   <= visible_d;
            frames_q    <= frames_d;
            toggles_q   <= toggles_d;
            show_pend_q <= show_pend_d;
            hide_pend_q <= hide_pend_d;
            v1_q        <= v1_d;
            sprite_on_q <= sprite_on_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
        end
    end

    assign sprite_on = sprite_on_q;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign state     = state_q;

endmodule
